// File: rtl/conv2_sched.sv
// Window sequencer for the conv2 binary-convolution engine: gathers 3x3x8 windows
// from the feature-map buffer, issues them to the engine and stores the results.
module conv2_sched #(
  parameter int IMG_W  = 13,
  parameter int IMG_H  = 13,
  parameter int IN_CH  = 8,
  parameter int OUT_CH = 16,
  parameter int K      = 3,
  parameter int AW     = 8,
  parameter int OW     = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   fm_rd_en,
  output logic [AW-1:0]          fm_rd_addr,
  input  logic [IN_CH-1:0]       fm_rd_data,
  output logic                   win_valid,
  output logic [K*K*IN_CH-1:0]   win_data,
  input  logic                   eng_valid,
  input  logic [OUT_CH-1:0]      eng_result,
  output logic                   out_wr_en,
  output logic [OW-1:0]          out_wr_addr,
  output logic [OUT_CH-1:0]      out_wr_data
);

  localparam int KK    = K * K;
  localparam int WIN_W = KK * IN_CH;
  localparam int OMW   = IMG_W - K + 1;
  localparam int OMH   = IMG_H - K + 1;
  localparam int NPOS  = OMW * OMH;
  localparam int CW    = $clog2(IMG_W);
  localparam int KW    = $clog2(KK + 1);

  localparam logic [KW-1:0] K_LAST   = KW'(KK - 1);
  localparam logic [CW-1:0] C_LAST   = CW'(OMW - 1);
  localparam logic [CW-1:0] R_LAST   = CW'(OMH - 1);
  localparam logic [OW-1:0] RES_FULL = OW'(NPOS);

  typedef enum logic [2:0] {IDLE, FETCH, LAST, ISSUE, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       r_q, r_d, c_q, c_d;
  logic [KW-1:0]       k_q, k_d;
  logic [KW-1:0]       cap_k_q;
  logic                cap_en_q;
  logic [WIN_W-1:0]    shadow_q, win_next;
  logic [WIN_W-1:0]    win_data_q;
  logic                win_valid_q;
  logic                busy_q, done_q, err_q;
  logic                fm_rd_en_q;
  logic [AW-1:0]       fm_rd_addr_q;
  logic [OW-1:0]       res_cnt_q;
  logic                out_wr_en_q;
  logic [OW-1:0]       out_wr_addr_q;
  logic [OUT_CH-1:0]   out_wr_data_q;
  logic                start_acc;
  logic                wr_ok;
  logic                err_set;

  function automatic logic [AW-1:0] pix_addr(input logic [CW-1:0] r,
                                             input logic [CW-1:0] c,
                                             input logic [KW-1:0] k);
    logic [KW-1:0] ky;
    logic [KW-1:0] kx;
    ky = k / KW'(K);
    kx = k % KW'(K);
    return (AW'(r) + AW'(ky)) * AW'(IMG_W) + AW'(c) + AW'(kx);
  endfunction

  assign start_acc = (state_q == IDLE) && start;
  // Results beyond the last output position, or outside a pass, are dropped and flagged.
  assign wr_ok     = eng_valid && (state_q != IDLE) && (res_cnt_q != RES_FULL);
  assign err_set   = eng_valid && ((state_q == IDLE) || (res_cnt_q == RES_FULL));

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (k_q == K_LAST) begin
          state_d = LAST;
          k_d     = '0;
        end else begin
          k_d     = k_q + KW'(1);
        end
      end
      LAST:  state_d = ISSUE;
      ISSUE: begin
        if (c_q == C_LAST) begin
          c_d = '0;
          r_d = r_q + CW'(1);
        end else begin
          c_d = c_q + CW'(1);
        end
        if ((r_q == R_LAST) && (c_q == C_LAST)) begin
          state_d = DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (res_cnt_q == RES_FULL) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data arrives one cycle after the strobe; merge it into slot cap_k of every channel.
  always_comb begin
    win_next = shadow_q;
    for (int ch = 0; ch < IN_CH; ch++) begin
      for (int kk = 0; kk < KK; kk++) begin
        win_next[ch*KK + kk] = (cap_k_q == KW'(kk)) ? fm_rd_data[ch] : shadow_q[ch*KK + kk];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      r_q           <= '0;
      c_q           <= '0;
      k_q           <= '0;
      cap_k_q       <= '0;
      cap_en_q      <= 1'b0;
      shadow_q      <= '0;
      win_data_q    <= '0;
      win_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      fm_rd_en_q    <= 1'b0;
      fm_rd_addr_q  <= '0;
      res_cnt_q     <= '0;
      out_wr_en_q   <= 1'b0;
      out_wr_addr_q <= '0;
      out_wr_data_q <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      c_q          <= c_d;
      k_q          <= k_d;
      busy_q       <= (state_d != IDLE) && (state_d != DONE);
      done_q       <= (state_d == DONE);
      fm_rd_en_q   <= (state_d == FETCH);
      fm_rd_addr_q <= (state_d == FETCH) ? pix_addr(r_d, c_d, k_d) : '0;
      cap_en_q     <= fm_rd_en_q;
      cap_k_q      <= k_q;
      if (cap_en_q) begin
        shadow_q <= win_next;
        // The final tap lands straight in the output window so it is complete during ISSUE.
        if (cap_k_q == K_LAST) begin
          win_data_q <= win_next;
        end
      end
      win_valid_q  <= (state_d == ISSUE);
      out_wr_en_q  <= wr_ok;
      if (wr_ok) begin
        out_wr_data_q <= eng_result;
        out_wr_addr_q <= res_cnt_q;
        res_cnt_q     <= res_cnt_q + OW'(1);
      end else if (start_acc) begin
        res_cnt_q <= '0;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign fm_rd_en    = fm_rd_en_q;
  assign fm_rd_addr  = fm_rd_addr_q;
  assign win_valid   = win_valid_q;
  assign win_data    = win_data_q;
  assign out_wr_en   = out_wr_en_q;
  assign out_wr_addr = out_wr_addr_q;
  assign out_wr_data = out_wr_data_q;

endmodule
